// File: rtl/spoofer_stream_ctrl.sv
// spoofer_stream_ctrl: Avalon-ST packet generator streaming a running sample count with configurable packet and gap lengths.
// Ports:
//   clk, rst (async active-low)
//   enable      - level, keep generating packets; stops only at a packet boundary
//   cfg_load    - pulse, latch pkt_len/gap_len (honoured only while idle)
//   pkt_len     - beats per packet (0 behaves as 1)
//   gap_len     - idle cycles inserted after each packet
//   sample_clr  - pulse, zero the sample counter (honoured only while idle)
//   src_*       - Avalon-ST source, readyLatency 0, data = zero-extended sample count
//   busy        - controller not idle
//   pkt_count   - completed packets, wrapping
module spoofer_stream_ctrl #(
    parameter int WIDTH     = 24,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 cfg_load,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    input  logic [LEN_WIDTH-1:0] gap_len,
    input  logic                 sample_clr,
    output logic [31:0]          src_data,
    output logic                 src_valid,
    input  logic                 src_ready,
    output logic                 src_sop,
    output logic                 src_eop,
    output logic                 busy,
    output logic [15:0]          pkt_count
);
    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] sample;
    logic [LEN_WIDTH-1:0] beat, gap_cnt, len_q, gap_q, last_beat;
    logic xfer, last_xfer, gap_done;
    // a latched length of 0 is a 1-beat packet
    assign last_beat = (len_q == '0) ? '0 : len_q - LEN_WIDTH'(1);
    assign src_valid = state == STREAM;
    assign src_sop   = src_valid && beat == '0;
    assign src_eop   = src_valid && beat == last_beat;
    assign src_data  = 32'(sample);
    assign busy      = state != IDLE;
    assign xfer      = src_valid && src_ready;
    assign last_xfer = xfer && src_eop;
    // gap_cnt counts up from 0 on entry, so the final gap cycle is gap_q-1
    assign gap_done  = gap_cnt == gap_q - LEN_WIDTH'(1);
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = enable ? STREAM : IDLE;
            STREAM:  state_nx = !last_xfer ? STREAM : (gap_q != '0) ? GAP : enable ? STREAM : IDLE;
            GAP:     state_nx = !gap_done ? GAP : enable ? STREAM : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sample    <= '0;
            beat      <= '0;
            gap_cnt   <= '0;
            pkt_count <= '0;
            len_q     <= LEN_WIDTH'(1);
            gap_q     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cfg_load) begin
                len_q <= pkt_len;
                gap_q <= gap_len;
            end
            if (state == IDLE && sample_clr)
                sample <= '0;
            else if (xfer)
                sample <= sample + WIDTH'(1);
            if (last_xfer)
                beat <= '0;
            else if (xfer)
                beat <= beat + LEN_WIDTH'(1);
            gap_cnt <= (state == GAP && !gap_done) ? gap_cnt + LEN_WIDTH'(1) : '0;
            if (last_xfer)
                pkt_count <= pkt_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_spoofer_stream_ctrl.sv
// tb_spoofer_stream_ctrl: directed bench with a transaction-level model, driving a 24-bit and a 4-bit counter instance in lockstep.
module tb_spoofer_stream_ctrl;
    logic clk = 0;
    logic rst = 0;
    logic enable = 0, cfg_load = 0, sample_clr = 0, src_ready = 1;
    logic [15:0] pkt_len = 0, gap_len = 0;
    logic [31:0] src_data, d4;
    logic src_valid, src_sop, src_eop, busy, v4, sop4, eop4, busy4;
    logic [15:0] pkt_count, pc4;
    int errors = 0, checks = 0, cyc = 0;

    spoofer_stream_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_load(cfg_load), .pkt_len(pkt_len),
        .gap_len(gap_len), .sample_clr(sample_clr), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop), .busy(busy), .pkt_count(pkt_count)
    );
    spoofer_stream_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .cfg_load(cfg_load), .pkt_len(pkt_len),
        .gap_len(gap_len), .sample_clr(sample_clr), .src_data(d4), .src_valid(v4),
        .src_ready(src_ready), .src_sop(sop4), .src_eop(eop4), .busy(busy4), .pkt_count(pc4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: the stream is a sequence of packets of len beats carrying a running
    // count, separated by gap idle cycles; mode 0 idle, 1 sending, 2 gap.
    int m_mode = 0, m_beat = 0, m_gap_left = 0, m_len = 1, m_gap = 0;
    int unsigned m_cnt = 0, m_pkts = 0;
    function automatic int plen();
        return (m_len == 0) ? 1 : m_len;
    endfunction
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_cnt = 0; m_beat = 0; m_gap_left = 0; m_pkts = 0; m_len = 1; m_gap = 0;
        end else if (m_mode == 0) begin
            if (cfg_load) begin
                m_len = int'(pkt_len);
                m_gap = int'(gap_len);
            end
            if (sample_clr) m_cnt = 0;
            if (enable) begin
                m_mode = 1;
                m_beat = 0;
            end
        end else if (m_mode == 1) begin
            if (src_ready) begin
                m_cnt++;
                if (m_beat == plen() - 1) begin
                    m_pkts++;
                    m_beat = 0;
                    if (m_gap > 0) begin
                        m_mode = 2;
                        m_gap_left = m_gap;
                    end else m_mode = enable ? 1 : 0;
                end else m_beat++;
            end
        end else begin
            m_gap_left--;
            if (m_gap_left == 0) m_mode = enable ? 1 : 0;
        end
    end

    typedef struct {logic [31:0] d; logic [31:0] d4; logic sop; logic eop; int cyc;} beat_t;
    beat_t beats[$];
    logic prev_stall = 0, prev_sop = 0, prev_eop = 0;
    logic [31:0] prev_data = 0;

    always @(negedge clk) begin
        chk("valid", src_valid, m_mode == 1);
        chk("data", src_data, m_cnt & 32'hFF_FFFF);
        chk("sop", src_sop, m_mode == 1 && m_beat == 0);
        chk("eop", src_eop, m_mode == 1 && m_beat == plen() - 1);
        chk("busy", busy, m_mode != 0);
        chk("pkt_count", pkt_count, m_pkts & 32'hFFFF);
        chk("valid_w4", v4, m_mode == 1);
        chk("data_w4", d4, m_cnt & 32'hF);
        chk("sop_w4", sop4, m_mode == 1 && m_beat == 0);
        chk("eop_w4", eop4, m_mode == 1 && m_beat == plen() - 1);
        chk("busy_w4", busy4, m_mode != 0);
        chk("pkt_count_w4", pc4, m_pkts & 32'hFFFF);
        if (prev_stall) begin
            chk("stall_valid", src_valid, 1);
            chk("stall_data", src_data, prev_data);
            chk("stall_sop", src_sop, prev_sop);
            chk("stall_eop", src_eop, prev_eop);
        end
        prev_stall = src_valid && !src_ready;
        prev_data = src_data;
        prev_sop = src_sop;
        prev_eop = src_eop;
        if (src_valid && src_ready) beats.push_back('{src_data, d4, src_sop, src_eop, cyc});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_beats(input int n);
        int k = 0;
        while (beats.size() < n && k < 200) begin
            tick(1);
            k++;
        end
        chk("beat_timeout", beats.size() >= n, 1);
    endtask
    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            tick(1);
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask
    task automatic cfg(input logic [15:0] pl, input logic [15:0] gl);
        pkt_len = pl;
        gap_len = gl;
        cfg_load = 1;
        tick(1);
        cfg_load = 0;
    endtask

    initial begin
        int p0, wraps;
        tick(2);
        chk("reset_valid", src_valid, 0);
        chk("reset_data", src_data, 0);
        chk("reset_busy", busy, 0);
        rst = 1;
        tick(1);
        // 4-beat packets with a 2-cycle gap
        cfg(4, 2);
        beats.delete();
        enable = 1;
        wait_beats(5);
        enable = 0;
        for (int i = 0; i < 5; i++) begin
            chk("p4_data", beats[i].d, i);
            chk("p4_sop", beats[i].sop, i == 0 || i == 4);
            chk("p4_eop", beats[i].eop, i == 3);
        end
        chk("p4_gap_cycles", beats[4].cyc - beats[3].cyc, 3);
        chk("p4_pkt_count", pkt_count, 1);
        wait_idle();
        // 1-beat packets back to back
        cfg(1, 0);
        beats.delete();
        p0 = int'(pkt_count);
        enable = 1;
        wait_beats(6);
        chk("p1_first_data", beats[0].d, 8);
        chk("p1_pkt_count", pkt_count, p0 + 6);
        for (int i = 0; i < 6; i++) begin
            chk("p1_sop", beats[i].sop, 1);
            chk("p1_eop", beats[i].eop, 1);
            if (i > 0) chk("p1_back_to_back", beats[i].cyc - beats[i-1].cyc, 1);
        end
        enable = 0;
        wait_idle();
        // random backpressure; a sample_clr mid-stream must be ignored
        cfg(3, 1);
        beats.delete();
        enable = 1;
        for (int i = 0; i < 60; i++) begin
            src_ready = 1'($urandom_range(0, 1));
            sample_clr = (i == 30);
            tick(1);
        end
        sample_clr = 0;
        src_ready = 1;
        enable = 0;
        wait_idle();
        chk("bp_whole_packets", beats.size() % 3, 0);
        for (int i = 0; i < beats.size(); i++) begin
            chk("bp_seq", beats[i].d, (beats[0].d + i) & 32'hFF_FFFF);
            chk("bp_sop", beats[i].sop, i % 3 == 0);
            chk("bp_eop", beats[i].eop, i % 3 == 2);
        end
        // 4-bit counter wraps within 20 beats
        cfg(5, 0);
        beats.delete();
        enable = 1;
        wait_beats(20);
        enable = 0;
        wait_idle();
        wraps = 0;
        for (int i = 0; i < 20; i++) begin
            chk("w4_seq", beats[i].d4, (beats[0].d4 + i) & 32'hF);
            if (i > 0 && beats[i-1].d4 == 15 && beats[i].d4 == 0) wraps++;
        end
        chk("w4_wrapped", wraps > 0, 1);
        // zero length behaves as one beat
        cfg(0, 1);
        beats.delete();
        enable = 1;
        tick(1);
        enable = 0;
        wait_idle();
        chk("len0_beats", beats.size(), 1);
        chk("len0_sop_eop", {31'd0, beats[0].sop & beats[0].eop}, 1);
        // enable dropped at beat 1; cfg_load mid-packet ignored
        cfg(4, 0);
        beats.delete();
        enable = 1;
        wait_beats(1);
        enable = 0;
        cfg(2, 3);
        wait_idle();
        chk("drop_beats", beats.size(), 4);
        chk("drop_eop", beats[3].eop, 1);
        chk("drop_busy", busy, 0);
        beats.delete();
        enable = 1;
        tick(1);
        enable = 0;
        wait_idle();
        chk("cfg_ignored_beats", beats.size(), 4);
        chk("cfg_ignored_eop1", beats[1].eop, 0);
        chk("cfg_ignored_eop3", beats[3].eop, 1);
        // sample_clr in idle
        sample_clr = 1;
        tick(1);
        sample_clr = 0;
        chk("clr_data", src_data, 0);
        chk("clr_data_w4", d4, 0);
        // reset mid-packet
        cfg(4, 0);
        beats.delete();
        enable = 1;
        wait_beats(2);
        chk("pre_rst_data", src_data, 2);
        rst = 0;
        #1;
        chk("rst_valid", src_valid, 0);
        chk("rst_data", src_data, 0);
        chk("rst_sop", src_sop, 0);
        chk("rst_eop", src_eop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_count", pkt_count, 0);
        tick(2);
        beats.delete();
        rst = 1;
        wait_beats(1);
        enable = 0;
        chk("post_rst_data", beats[0].d, 0);
        chk("post_rst_sop", beats[0].sop, 1);
        wait_idle();
        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
